booth_pp_accumulate: RTL
========================

BOOTH_PP_ACCUMULATE -- requirements
Module: booth_pp_accumulate

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have the port in_valid, input, 1 bit: operand pair X/Y valid.
REQ-004 The block SHALL have the port in_ready, output, 1 bit: block can accept operands.
REQ-005 The block SHALL have the port X, input, 32 bits: signed two's-complement multiplicand.
REQ-006 The block SHALL have the port Y, input, 32 bits: signed two's-complement multiplier.
REQ-007 The block SHALL have the port out_valid, output, 1 bit: product P valid.
REQ-008 The block SHALL have the port out_ready, input, 1 bit: consumer accepts P.
REQ-009 The block SHALL have the port P, output, 64 bits: signed product X*Y.
REQ-010 The block SHALL have the port busy, output, 1 bit: high while in the RUN or DONE state.

Function
REQ-011 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
- in_ready=1 only in IDLE.
- busy=1 in RUN and in DONE.
- out_valid=1 only in DONE.
REQ-012 When in_valid&in_ready is high at an edge, the block SHALL register X and Y and enter RUN.
REQ-013 In RUN, the block SHALL process one radix-4 Booth group per cycle, from group i=0 up to group i=15.
- Triplet = {Y[2i+1], Y[2i], Y[2i-1]}, with Y[-1]=0.
REQ-014 The partial product SHALL be selected from the triplet as follows:
- 000 or 111: 0
- 001 or 010: +X
- 011: +2X
- 100: -2X
- 101 or 110: -X
REQ-015 A negative partial product SHALL be formed as the bitwise inverse of the 33-bit {X,0} or sign-extended X, plus a carry-in equal to the triplet MSB (sign).
REQ-016 The partial product SHALL be weighted by 4^i.
REQ-017 The accumulator SHALL be at least 66 bits signed, with full sign extension, so that no overflow or truncation occurs before the final result.
REQ-018 P SHALL equal the exact signed 64-bit product for all 2^64 operand pairs, including X=Y=0x80000000.
REQ-019 Latency SHALL be fixed: out_valid=1 exactly 16 rising edges after the accepting edge (feature macro absent).
REQ-020 While out_valid=1 and out_ready=0, P and out_valid SHALL hold stable indefinitely.
REQ-021 When out_valid&out_ready is high at an edge, the block SHALL return to IDLE, with out_valid=0 and in_ready=1 from that edge.
- No same-edge acceptance of new operands.
REQ-022 The block SHALL ignore in_valid while in RUN or DONE, and X/Y changes after acceptance SHALL NOT affect P.
REQ-023 P SHALL retain the last product in IDLE until the next completion overwrites it.

Reset
REQ-024 When rst_n=0 at an edge, the block SHALL enter IDLE and set the outputs to in_ready=1, out_valid=0, busy=0, P=64'h0, and the accumulator and counter to 0.
REQ-025 Reset asserted during RUN or DONE SHALL abort the operation, discard the pending result, and produce no out_valid pulse afterwards.
REQ-026 The first acceptance SHALL be possible at the first edge with rst_n=1.

Configuration
REQ-027 The block SHALL support the macro BOOTH_EARLY_EXIT_EN.
- When defined, RUN SHALL end after group i when Y[31:2i+1] are all zero.
- The remaining triplets then all encode 0.
- Latency SHALL be max(1, number of groups processed).
- P SHALL remain exact, with the accumulator realigned by the skipped weight.
REQ-028 When BOOTH_EARLY_EXIT_EN is undefined, the block SHALL always process 16 groups, as in REQ-019.
REQ-029 Handshake rules and reset behaviour SHALL be identical with and without BOOTH_EARLY_EXIT_EN.

Verification
REQ-030 The bench SHALL drive X=3, Y=5 with out_ready=1.
- Response: P=64'h000000000000000F, with out_valid 16 edges after acceptance (macro absent).
REQ-031 The bench SHALL drive X=32'hFFFFFFFF, Y=32'hFFFFFFFF.
- Response: P=64'h0000000000000001.
REQ-032 The bench SHALL drive X=Y=32'h80000000.
- Response: P=64'h4000000000000000.
REQ-033 The bench SHALL drive X=32'h7FFFFFFF, Y=32'h80000000, with out_ready=0 for 5 cycles after out_valid.
- Response: P=64'hC000000080000000, held stable.
- in_ready=0 throughout the hold.
- IDLE on the edge where out_ready=1.
REQ-034 The bench SHALL drive rst_n=0 for one edge at RUN cycle 7, then new operands X=2, Y=-3.
- Response: no out_valid from the aborted operation.
- Then P=64'hFFFFFFFFFFFFFFFA.
REQ-035 The bench SHALL drive Y=3, X=10 and Y=0, X=10 with BOOTH_EARLY_EXIT_EN defined.
- Response for Y=3: P=30 after a latency of 2 edges.
- Response for Y=0: P=0 after a latency of 1 edge.

Source files
------------

// File: rtl/booth_pp_accumulate.sv
// +----------------------------------------------------------------------------+
// | booth_pp_accumulate : sequential radix-4 Booth 32x32 signed multiplier     |
// | Optional macro BOOTH_EARLY_EXIT_EN : stop once remaining groups are zero   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module booth_pp_accumulate (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] P,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic [65:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] p_q, p_d;

  logic [32:0] y_ext;
  logic [2:0]  trip;
  logic [32:0] mag;
  logic [32:0] pp33;
  logic [65:0] pp_ext;
  logic [65:0] pp_sh;
  logic [65:0] acc_sum;
  logic        last_grp;

  // Booth recoding of group cnt_q; y_ext supplies the implicit Y[-1]=0.
  always_comb begin
    y_ext = {y_q, 1'b0};
    trip  = y_ext[{cnt_q, 1'b0} +: 3];
    case (trip)
      3'b001, 3'b010, 3'b101, 3'b110: mag = {x_q[31], x_q};
      3'b011, 3'b100:                 mag = {x_q, 1'b0};
      default:                        mag = 33'd0;
    endcase
    pp33    = trip[2] ? ~mag : mag;
    pp_ext  = {{33{pp33[32]}}, pp33} + {65'd0, trip[2]};
    pp_sh   = pp_ext << {cnt_q, 1'b0};
    acc_sum = acc_q + pp_sh;
  end

  // Partial products carry absolute weight, so stopping early needs no
  // realignment: every skipped group would have contributed zero.
`ifdef BOOTH_EARLY_EXIT_EN
  assign last_grp = (cnt_q == 4'd15) || ((y_q >> {cnt_q, 1'b1}) == 32'd0);
`else
  assign last_grp = (cnt_q == 4'd15);
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = X;
          y_d     = Y;
          acc_d   = 66'd0;
          cnt_d   = 4'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_sum;
        if (last_grp) begin
          p_d     = acc_sum[63:0];
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= 32'd0;
      y_q     <= 32'd0;
      acc_q   <= 66'd0;
      cnt_q   <= 4'd0;
      p_q     <= 64'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign P         = p_q;

endmodule

`default_nettype wire
